// File: rtl/nerf_fix_pkg.sv
// Shared Q12.4 fixed-point helpers for the NeRF pipeline, plus the ray_gen
// controller state type.
package nerf_fix_pkg;

    localparam int FIX_INT_BITS   = 12;
    localparam int FIX_FRAC_BITS  = 4;
    localparam int FIX_TOTAL_BITS = 16;
    localparam int PIX_BITS       = 12;

    localparam logic [15:0] FIX_ONE     = 16'h0010;
    localparam logic [15:0] FIX_NEG_ONE = 16'hFFF0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rg_state_t;

    // Clamp a wide signed intermediate to the 16-bit signed range.
    function automatic logic [15:0] sat16(input logic signed [39:0] v);
        logic [15:0] res;
        if (v > 40'sd32767) begin
            res = 16'h7FFF;
        end else if (v < -40'sd32768) begin
            res = 16'h8000;
        end else begin
            res = v[15:0];
        end
        return res;
    endfunction

    // Full-precision signed 16x16 product.
    function automatic logic signed [31:0] fix_mul(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] a_ext;
        logic signed [31:0] b_ext;
        a_ext = {{16{a[15]}}, a};
        b_ext = {{16{b[15]}}, b};
        return a_ext * b_ext;
    endfunction

endpackage

// File: rtl/ray_gen_if.sv
// Bundle between ray_gen and the sample-point stage: frame control, camera
// inputs and the streamed ray.
interface ray_gen_if;
    // A ray transfers on any rising edge where ray_valid && ray_ready; once
    // ray_valid is high it stays high with all ray fields stable until that edge.
    logic                      start;
    logic [15:0]               inv_focal;
    logic [191:0]              c2w;
    logic                      busy;
    logic                      done;
    logic                      ray_valid;
    logic                      ray_ready;
    logic [47:0]               rays_o;
    logic [47:0]               rays_d;
    logic [11:0]               pix_x;
    logic [11:0]               pix_y;
    logic                      ray_last;
    nerf_fix_pkg::rg_state_t   dbg_state;

    modport master (
        input  start, inv_focal, c2w, ray_ready,
        output busy, done, ray_valid, rays_o, rays_d, pix_x, pix_y, ray_last, dbg_state
    );

    modport slave (
        output start, inv_focal, c2w, ray_ready,
        input  busy, done, ray_valid, rays_o, rays_d, pix_x, pix_y, ray_last, dbg_state
    );
endinterface

// File: rtl/mat3_vec_fix.sv
// Two-stage 3x3 matrix times 3-vector in Q12.4: products, then sum/shift/
// saturate. Both stages hold when i_en is low; a sideband rides along.
module mat3_vec_fix
    import nerf_fix_pkg::*;
#(
    parameter int FRAC_BITS = 4,
    parameter int SB_W      = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_en,
    input  logic            i_valid,
    input  logic [143:0]    i_m,
    input  logic [47:0]     i_v,
    input  logic [SB_W-1:0] i_sb,
    output logic            o_valid,
    output logic [47:0]     o_y,
    output logic [SB_W-1:0] o_sb
);

    logic signed [31:0] r_p [3][3];
    logic               r_v1;
    logic [SB_W-1:0]    r_sb1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1  <= 1'b0;
            r_sb1 <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_p[r][c] <= '0;
                end
            end
        end else if (i_en) begin
            r_v1  <= i_valid;
            r_sb1 <= i_sb;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_p[r][c] <= fix_mul(i_m[16*(3*r+c) +: 16], i_v[16*c +: 16]);
                end
            end
        end
    end

    // 34-bit sum cannot overflow for three 32-bit products.
    logic signed [33:0] w_sum [3];
    logic signed [33:0] w_sh  [3];
    logic [47:0]        w_y;

    always_comb begin
        w_y = '0;
        for (int r = 0; r < 3; r++) begin
            w_sum[r] = {{2{r_p[r][0][31]}}, r_p[r][0]}
                     + {{2{r_p[r][1][31]}}, r_p[r][1]}
                     + {{2{r_p[r][2][31]}}, r_p[r][2]};
            w_sh[r]  = w_sum[r] >>> FRAC_BITS;
            w_y[16*r +: 16] = sat16({{6{w_sh[r][33]}}, w_sh[r]});
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_y     <= '0;
            o_sb    <= '0;
        end else if (i_en) begin
            o_valid <= r_v1;
            o_y     <= w_y;
            o_sb    <= r_sb1;
        end
    end

endmodule

// File: rtl/ray_gen.sv
// Per-pixel camera ray generator: raster-order pixel issue, dx/dy stage, then
// a two-stage camera-to-world rotation. The whole pipe stalls on back-pressure.
module ray_gen
    import nerf_fix_pkg::*;
#(
    parameter int IMG_W      = 4,
    parameter int IMG_H      = 2,
    parameter int INT_BITS   = 12,
    parameter int FRAC_BITS  = 4,
    parameter int TOTAL_BITS = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    ray_gen_if.master bus
);

    localparam int          HALF_W = IMG_W / 2;
    localparam int          HALF_H = IMG_H / 2;
    localparam logic [11:0] LAST_X = 12'(IMG_W - 1);
    localparam logic [11:0] LAST_Y = 12'(IMG_H - 1);
    localparam int          SB_W   = 1 + 2 * PIX_BITS + 48;

    if (INT_BITS + FRAC_BITS != TOTAL_BITS || TOTAL_BITS != FIX_TOTAL_BITS
        || FRAC_BITS != FIX_FRAC_BITS) begin : g_fmt_check
        $error("ray_gen: fixed-point format must be Q12.4");
    end

    rg_state_t    r_state;
    logic [191:0] r_c2w;
    logic [15:0]  r_inv;
    logic [11:0]  r_px;
    logic [11:0]  r_py;
    logic [15:0]  r_dx;
    logic [15:0]  r_dy;
    logic         r_s0_valid;
    logic         r_busy;
    logic         r_done;

    logic              w_out_valid;
    logic              w_out_last;
    logic [SB_W-1:0]   w_sb_out;
    logic              w_adv;
    logic              w_s0_last;
    logic              w_step;
    logic              w_hs_last;
    logic [11:0]       w_nx;
    logic [11:0]       w_ny;
    logic [15:0]       w_inv_sel;
    logic signed [31:0] w_xoff;
    logic signed [31:0] w_yoff;
    logic signed [31:0] w_dx_p;
    logic signed [31:0] w_dy_p;
    logic [15:0]       w_dx;
    logic [15:0]       w_dy;

    assign w_adv     = !w_out_valid || bus.ray_ready;
    assign w_s0_last = r_s0_valid && (r_px == LAST_X) && (r_py == LAST_Y);
    assign w_step    = (r_state == ST_RUN) && w_adv && !w_s0_last;
    assign w_hs_last = w_out_valid && bus.ray_ready && w_out_last;

    // Next pixel into S0; in IDLE this is (0,0) using the live inv_focal so
    // pixel 0 enters S0 on the same edge that accepts start.
    always_comb begin
        w_nx      = '0;
        w_ny      = '0;
        w_inv_sel = (r_state == ST_IDLE) ? bus.inv_focal : r_inv;
        if (w_step) begin
            if (r_px == LAST_X) begin
                w_nx = '0;
                w_ny = r_py + 12'd1;
            end else begin
                w_nx = r_px + 12'd1;
                w_ny = r_py;
            end
        end
    end

    assign w_xoff = $signed({20'd0, w_nx}) - HALF_W;
    assign w_yoff = HALF_H - $signed({20'd0, w_ny});
    assign w_dx_p = w_xoff * $signed({{16{w_inv_sel[15]}}, w_inv_sel});
    assign w_dy_p = w_yoff * $signed({{16{w_inv_sel[15]}}, w_inv_sel});
    assign w_dx   = sat16({{8{w_dx_p[31]}}, w_dx_p});
    assign w_dy   = sat16({{8{w_dy_p[31]}}, w_dy_p});

    // Controller and S0 (pixel counters + dx/dy).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_c2w      <= '0;
            r_inv      <= '0;
            r_px       <= '0;
            r_py       <= '0;
            r_dx       <= '0;
            r_dy       <= '0;
            r_s0_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state    <= ST_RUN;
                        r_c2w      <= bus.c2w;
                        r_inv      <= bus.inv_focal;
                        r_px       <= '0;
                        r_py       <= '0;
                        r_dx       <= w_dx;
                        r_dy       <= w_dy;
                        r_s0_valid <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_adv) begin
                        if (w_s0_last) begin
                            r_s0_valid <= 1'b0;
                            r_state    <= ST_DRAIN;
                        end else begin
                            r_px <= w_nx;
                            r_py <= w_ny;
                            r_dx <= w_dx;
                            r_dy <= w_dy;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Stay out of IDLE through the done cycle so a start
                    // coinciding with done is not taken.
                    if (w_hs_last) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                    if (r_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    logic [143:0] w_m;
    logic [47:0]  w_org;

    always_comb begin
        w_m   = '0;
        w_org = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w_m[16*(3*r+c) +: 16] = r_c2w[16*(4*r+c) +: 16];
            end
            w_org[16*r +: 16] = r_c2w[16*(4*r+3) +: 16];
        end
    end

    mat3_vec_fix #(
        .FRAC_BITS (FRAC_BITS),
        .SB_W      (SB_W)
    ) u_mat (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_adv),
        .i_valid (r_s0_valid),
        .i_m     (w_m),
        .i_v     ({FIX_NEG_ONE, r_dy, r_dx}),
        .i_sb    ({w_s0_last, r_py, r_px, w_org}),
        .o_valid (w_out_valid),
        .o_y     (bus.rays_d),
        .o_sb    (w_sb_out)
    );

    assign {w_out_last, bus.pix_y, bus.pix_x, bus.rays_o} = w_sb_out;
    assign bus.ray_last  = w_out_last;
    assign bus.ray_valid = w_out_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_ray_gen.sv
// Directed bench for ray_gen (4x2 image): latency, ray values, saturation,
// back-pressure, ignored start and mid-frame reset.
module tb_ray_gen;
    import nerf_fix_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    ray_gen_if bus();

    ray_gen #(
        .IMG_W      (4),
        .IMG_H      (2),
        .INT_BITS   (12),
        .FRAC_BITS  (4),
        .TOTAL_BITS (16)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic [120:0] exp_q[$];
    logic [120:0] got_q[$];
    int s_cyc;
    int first_cyc;
    int done_cyc;
    bit done_seen;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [191:0] c2w_set(input logic [191:0] base, input int r, input int c,
                                             input logic [15:0] v);
        logic [191:0] m;
        m = base;
        m[16*(4*r+c) +: 16] = v;
        return m;
    endfunction

    // Expected ray for identity c2w, zero origin, inv_focal = 1.0.
    function automatic logic [120:0] id_ray(input int px, input int py);
        logic [15:0] dx;
        logic [15:0] dy;
        dx = 16'((px - 2) * 16);
        dy = 16'((1 - py) * 16);
        return {(px == 3 && py == 1), 12'(py), 12'(px), 48'd0, 16'hFFF0, dy, dx};
    endfunction

    function automatic logic [120:0] cur_ray();
        return {bus.ray_last, bus.pix_y, bus.pix_x, bus.rays_o, bus.rays_d};
    endfunction

    task automatic run_frame(input logic [191:0] m, input logic [15:0] invf,
                             input bit rand_ready, input bit poke);
        logic [120:0] prev;
        bit prev_stall;
        got_q.delete();
        done_seen  = 1'b0;
        first_cyc  = -1;
        done_cyc   = -1;
        prev_stall = 1'b0;
        prev       = '0;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.c2w       = m;
        bus.inv_focal = invf;
        bus.ray_ready = 1'b1;
        s_cyc         = cyc;
        for (int it = 0; it < 200 && !done_seen; it++) begin
            @(negedge clk);
            bus.start = poke && (it == 4);
            if (poke && it == 4) begin
                bus.c2w       = '0;
                bus.inv_focal = 16'h0100;
            end
            #1;
            if (prev_stall) begin
                check("stall_valid", bus.ray_valid, 1'b1);
                check("stall_hold", cur_ray(), prev);
            end
            if (it == 0) check("busy_after_start", bus.busy, 1'b1);
            if (bus.ray_valid && first_cyc < 0) first_cyc = cyc;
            if (bus.done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                check("busy_low_at_done", bus.busy, 1'b0);
            end
            bus.ray_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.ray_valid && bus.ray_ready) got_q.push_back(cur_ray());
            prev_stall = bus.ray_valid && !bus.ray_ready;
            prev       = cur_ray();
        end
        bus.start     = 1'b0;
        bus.ray_ready = 1'b1;
        check("done_seen", done_seen, 1'b1);
    endtask

    task automatic compare_frame(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check($sformatf("%s_ray%0d", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    initial begin
        logic [191:0] ident;
        logic [191:0] m_row;
        logic [120:0] r;
        bit done_in_reset;

        bus.start     = 1'b0;
        bus.c2w       = '0;
        bus.inv_focal = '0;
        bus.ray_ready = 1'b1;

        ident = '0;
        ident = c2w_set(ident, 0, 0, 16'h0010);
        ident = c2w_set(ident, 1, 1, 16'h0010);
        ident = c2w_set(ident, 2, 2, 16'h0010);
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 4; x++) exp_q.push_back(id_ray(x, y));
        end

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", bus.ray_valid, 1'b0);
        check("rst_rays_d", bus.rays_d, 48'd0);
        check("rst_rays_o", bus.rays_o, 48'd0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_state", bus.dbg_state, ST_IDLE);
        rst_n = 1'b1;

        // Identity camera, free-running
        run_frame(ident, 16'h0010, 1'b0, 1'b0);
        check("first_valid_cycle", first_cyc, s_cyc + 3);
        check("done_cycle", done_cyc, s_cyc + 11);
        compare_frame("ident");
        if (got_q.size() == 8) begin
            r = got_q[0];
            check("pix00_rays_d", r[47:0], {16'hFFF0, 16'h0010, 16'hFFE0});
            r = got_q[7];
            check("pix31_rays_d", r[47:0], {16'hFFF0, 16'h0000, 16'h0010});
        end

        // Row 0 = (0, 16, 0, 80)
        m_row = c2w_set(ident, 0, 0, 16'h0000);
        m_row = c2w_set(m_row, 0, 1, 16'h0010);
        m_row = c2w_set(m_row, 0, 3, 16'h0050);
        run_frame(m_row, 16'h0010, 1'b0, 1'b0);
        check("row0_count", got_q.size(), 8);
        if (got_q.size() == 8) begin
            r = got_q[0];
            check("row0_d0", r[15:0], 16'h0010);
            check("row0_o0", r[63:48], 16'h0050);
            r = got_q[7];
            check("row0_d0_last", r[15:0], 16'h0000);
        end

        // Saturating inv_focal
        run_frame(ident, 16'h7FFF, 1'b0, 1'b0);
        check("sat_count", got_q.size(), 8);
        if (got_q.size() == 8) begin
            r = got_q[0];
            check("sat_pix00_d0", r[15:0], 16'h8000);
            check("sat_pix00_d1", r[31:16], 16'h7FFF);
            check("sat_pix00_d2", r[47:32], 16'hFFF0);
            r = got_q[7];
            check("sat_pix31_d0", r[15:0], 16'h7FFF);
        end

        // Random back-pressure
        run_frame(ident, 16'h0010, 1'b1, 1'b0);
        compare_frame("stall");

        // start pulsed during RUN is ignored
        run_frame(ident, 16'h0010, 1'b0, 1'b1);
        check("poke_done_cycle", done_cyc, s_cyc + 11);
        compare_frame("poke");

        // Reset mid-frame
        @(negedge clk);
        bus.start     = 1'b1;
        bus.c2w       = ident;
        bus.inv_focal = 16'h0010;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_valid", bus.ray_valid, 1'b0);
        check("midrst_rays_d", bus.rays_d, 48'd0);
        check("midrst_rays_o", bus.rays_o, 48'd0);
        check("midrst_pix", {bus.pix_y, bus.pix_x, bus.ray_last}, 25'd0);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_state", bus.dbg_state, ST_IDLE);
        rst_n = 1'b1;
        done_in_reset = 1'b0;
        repeat (15) begin
            @(negedge clk);
            #1;
            if (bus.done) done_in_reset = 1'b1;
        end
        check("midrst_no_done", done_in_reset, 1'b0);
        run_frame(ident, 16'h0010, 1'b0, 1'b0);
        compare_frame("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
